mcs4_prn_emu: RTL and testbench



---
 rtl/mcs4_prn_emu_if.sv | 21 ++
 rtl/mcs4_prn_emu.sv | 137 +++++++++++++
 tb/tb_mcs4_prn_emu.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mcs4_prn_emu_if.sv
// Signal bundle between the CPU/host side and the printer emulation block.
// The master drives the fire strobe, hammer pattern and host command; the slave drives the rest.
interface mcs4_prn_emu_if;
    logic        PRN_FIRE;
    logic [16:0] PRN_HAMMER;
    logic        PRN_SECTOR;
    logic        PRN_INDEX;
    logic [3:0]  PRN_ROW;
    logic [31:0] PORT_CMD;
    logic [31:0] PORT_RES;

    modport master (
        output PRN_FIRE, PRN_HAMMER, PORT_CMD,
        input  PRN_SECTOR, PRN_INDEX, PRN_ROW, PORT_RES
    );

    modport slave (
        input  PRN_FIRE, PRN_HAMMER, PORT_CMD,
        output PRN_SECTOR, PRN_INDEX, PRN_ROW, PORT_RES
    );
endinterface

// File: rtl/mcs4_prn_emu.sv
// MCS-4 printer emulation: drum sector/index timer, hammer-fire record FIFO and
// a host command/response port that drains records one pop at a time.
module mcs4_prn_emu #(
    parameter int unsigned SECTOR_CYCLES = 2000,
    parameter int unsigned PULSE_CYCLES  = 200,
    parameter int unsigned NUM_ROWS      = 13,
    parameter int unsigned FIFO_AW       = 4
) (
    input logic           CLK,
    input logic           RES,
    mcs4_prn_emu_if.slave prn
);
    localparam int unsigned CycW  = $clog2(SECTOR_CYCLES);
    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam int unsigned CntW  = FIFO_AW + 1;
    localparam int unsigned RecW  = 21;

    // Drum timer
    logic [CycW-1:0] cyc_q, cyc_d;
    logic [3:0]      row_q, row_d;
    logic            wrap;

    always_comb begin
        wrap  = (cyc_q == CycW'(SECTOR_CYCLES - 1));
        cyc_d = wrap ? '0 : cyc_q + CycW'(1);
        row_d = row_q;
        if (wrap) begin
            row_d = (row_q == 4'(NUM_ROWS - 1)) ? 4'd0 : row_q + 4'd1;
        end
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            cyc_q <= '0;
            row_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            row_q <= row_d;
        end
    end

    logic sector;
    assign sector         = (cyc_q < CycW'(PULSE_CYCLES));
    assign prn.PRN_SECTOR = sector;
    assign prn.PRN_INDEX  = sector & (row_q == 4'd0);
    assign prn.PRN_ROW    = row_q;

    // Fire edge detect and command register
    logic fire_q, push;
    logic cmd_vld_q, cmd_pop_q, cmd_clr_q;
    logic pop_lvl, pop_lvl_q, clr_lvl, clr_lvl_q;
    logic pop_req, clr_req;
    logic unused_cmd;

    assign unused_cmd = ^{prn.PORT_CMD[30:16], prn.PORT_CMD[13:0]};

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            fire_q    <= 1'b0;
            cmd_vld_q <= 1'b0;
            cmd_pop_q <= 1'b0;
            cmd_clr_q <= 1'b0;
            pop_lvl_q <= 1'b0;
            clr_lvl_q <= 1'b0;
        end else begin
            fire_q    <= prn.PRN_FIRE;
            cmd_vld_q <= prn.PORT_CMD[31];
            cmd_pop_q <= prn.PORT_CMD[15];
            cmd_clr_q <= prn.PORT_CMD[14];
            pop_lvl_q <= pop_lvl;
            clr_lvl_q <= clr_lvl;
        end
    end

    assign push    = prn.PRN_FIRE & ~fire_q;
    assign pop_lvl = cmd_vld_q & cmd_pop_q;
    assign clr_lvl = cmd_vld_q & cmd_clr_q;
    assign pop_req = pop_lvl & ~pop_lvl_q;
    assign clr_req = clr_lvl & ~clr_lvl_q;

    // Record FIFO; storage needs no reset since the pointers define validity
    logic [RecW-1:0]    mem [Depth];
    logic [FIFO_AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        res_q, res_d;
    logic               full, empty, do_push, do_pop, drop;

    always_comb begin
        full    = (count_q == CntW'(Depth));
        empty   = (count_q == '0);
        do_push = push & ~full;
        drop    = push & full;
        do_pop  = pop_req & ~empty;

        wptr_d  = do_push ? wptr_q + FIFO_AW'(1) : wptr_q;
        rptr_d  = do_pop ? rptr_q + FIFO_AW'(1) : rptr_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase

        // A drop in the same cycle as a clear leaves the flag set
        ovf_d = ovf_q;
        if (clr_req) ovf_d = 1'b0;
        if (drop)    ovf_d = 1'b1;

        res_d = res_q;
        if (pop_req) begin
            if (empty) res_d = {1'b1, 29'b0, ovf_q, 1'b0};
            else       res_d = {1'b1, mem[rptr_q], 8'b0, ovf_q, 1'b1};
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem[wptr_q] <= {prn.PRN_HAMMER, row_q};
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            res_q   <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            res_q   <= res_d;
        end
    end

    assign prn.PORT_RES = res_q;
endmodule

// File: tb/tb_mcs4_prn_emu.sv
// Bench for mcs4_prn_emu: directed vector table, hand-written corner sequences and
// randomized traffic against a queue-based model of the drum and record FIFO.
module tb_mcs4_prn_emu;
    localparam int unsigned S     = 10;
    localparam int unsigned P     = 2;
    localparam int unsigned N     = 13;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic CLK = 1'b0;
    logic RES = 1'b1;

    mcs4_prn_emu_if bus ();

    mcs4_prn_emu #(
        .SECTOR_CYCLES(S),
        .PULSE_CYCLES (P),
        .NUM_ROWS     (N),
        .FIFO_AW      (AW)
    ) dut (
        .CLK(CLK),
        .RES(RES),
        .prn(bus)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [16:0] hammer;
        logic [3:0]  row;
    } rec_t;

    typedef struct {
        int unsigned op;  // 0 = fire at row, 1 = pop
        logic [16:0] hammer;
        int unsigned row;
        logic [31:0] exp;
    } vec_t;

    int          checks   = 0;
    int          failures = 0;
    int unsigned ncyc;
    rec_t        model_q[$];
    logic        model_ovf = 1'b0;

    // Clock edges since the end of reset: the drum position follows from this alone
    always @(posedge CLK or posedge RES) begin
        if (RES) ncyc <= 0;
        else     ncyc <= ncyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int unsigned model_row();
        return (ncyc / S) % N;
    endfunction

    always @(negedge CLK) begin
        if (!RES) begin
            int unsigned r;
            logic        sec;
            r   = model_row();
            sec = ((ncyc % S) < P);
            check("row", 32'(bus.PRN_ROW), r);
            check("sector", 32'(bus.PRN_SECTOR), 32'(sec));
            check("index", 32'(bus.PRN_INDEX), 32'(sec && r == 0));
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic model_push(input logic [16:0] h, input logic [3:0] r);
        rec_t e;
        e.hammer = h;
        e.row    = r;
        if (model_q.size() < DEPTH) model_q.push_back(e);
        else                        model_ovf = 1'b1;
    endtask

    task automatic model_pop(output logic [31:0] exp);
        rec_t e;
        if (model_q.size() == 0) begin
            exp = {1'b1, 29'b0, model_ovf, 1'b0};
        end else begin
            e   = model_q.pop_front();
            exp = {1'b1, e.hammer, e.row, 8'b0, model_ovf, 1'b1};
        end
    endtask

    task automatic fire(input logic [16:0] h);
        bus.PRN_FIRE   = 1'b1;
        bus.PRN_HAMMER = h;
        model_push(h, 4'(model_row()));
        tick();
        bus.PRN_FIRE   = 1'b0;
        bus.PRN_HAMMER = 17'($urandom);
        tick();
    endtask

    task automatic pop(input string name, input logic [7:0] lo, output logic [31:0] got);
        logic [31:0] exp;
        model_pop(exp);
        bus.PORT_CMD = {24'h800080, lo};
        tick();
        tick();
        check(name, bus.PORT_RES, exp);
        got          = bus.PORT_RES;
        bus.PORT_CMD = 32'h8000_0000;
        tick();
        tick();
    endtask

    task automatic clear_ovf();
        bus.PORT_CMD = 32'h8000_4000;
        tick();
        tick();
        model_ovf    = 1'b0;
        bus.PORT_CMD = 32'h8000_0000;
        tick();
        tick();
    endtask

    task automatic wait_row(input int unsigned r);
        int n = 0;
        while (model_row() != r && n < int'(2 * S * N)) begin
            tick();
            n++;
        end
        if (model_row() != r) begin
            checks++;
            failures++;
            $display("FAIL wait_row: reached row %0d, required %0d", model_row(), r);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        vecs[9];
        logic [31:0] got, prev, exp;

        vecs[0] = '{0, 17'h0000A, 1, 32'h0};
        vecs[1] = '{1, 17'h0, 0, 32'h8002_8401};
        vecs[2] = '{1, 17'h0, 0, 32'h8000_0000};
        vecs[3] = '{0, 17'h0, 11, 32'h0};
        vecs[4] = '{0, 17'h0, 12, 32'h0};
        vecs[5] = '{0, 17'h0, 0, 32'h0};
        vecs[6] = '{1, 17'h0, 0, 32'h8000_2C01};
        vecs[7] = '{1, 17'h0, 0, 32'h8000_3001};
        vecs[8] = '{1, 17'h0, 0, 32'h8000_0001};

        bus.PRN_FIRE   = 1'b0;
        bus.PRN_HAMMER = '0;
        bus.PORT_CMD   = '0;
        repeat (3) @(posedge CLK);
        #1 RES = 1'b0;

        // Reset state and the full drum revolution
        check("reset_res", bus.PORT_RES, 32'h0);
        check("reset_row", 32'(bus.PRN_ROW), 32'h0);
        check("reset_index", 32'(bus.PRN_INDEX), 32'h1);
        repeat (129) tick();
        check("row_before_wrap", 32'(bus.PRN_ROW), 32'd12);
        tick();
        check("row_after_wrap", 32'(bus.PRN_ROW), 32'd0);

        // Directed vectors: single record and row ordering
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].op == 0) begin
                wait_row(vecs[i].row);
                fire(vecs[i].hammer);
            end else begin
                pop("vec_pop_model", 8'h00, got);
                check($sformatf("vec_%0d", i), got, vecs[i].exp);
            end
        end

        // Held pop pops once; invalid command pops nothing
        fire(17'h1_2345);
        fire(17'h0_ABCD);
        model_pop(exp);
        bus.PORT_CMD = 32'h8000_8000;
        repeat (100) tick();
        check("held_pop", bus.PORT_RES, exp);
        prev         = bus.PORT_RES;
        bus.PORT_CMD = 32'h8000_0000;
        tick();
        tick();
        bus.PORT_CMD = 32'h0000_8000;
        repeat (4) tick();
        check("invalid_cmd_nopop", bus.PORT_RES, prev);
        bus.PORT_CMD = 32'h0000_0000;
        tick();
        tick();
        pop("held_second", 8'h00, got);
        pop("held_empty", 8'h00, got);

        // Fire edge and pop edge in the same cycle, with one record then with none
        for (int k = 0; k < 2; k++) begin
            if (k == 0) fire(17'h1_0001);
            model_pop(exp);
            bus.PORT_CMD = 32'h8000_8000;
            tick();
            bus.PRN_FIRE   = 1'b1;
            bus.PRN_HAMMER = 17'h0_7777 + 17'(k);
            model_push(bus.PRN_HAMMER, 4'(model_row()));
            tick();
            bus.PRN_FIRE = 1'b0;
            check($sformatf("simul_pop_%0d", k), bus.PORT_RES, exp);
            check($sformatf("simul_valid_%0d", k), 32'(bus.PORT_RES[0]), 32'(k == 0));
            bus.PORT_CMD = 32'h8000_0000;
            tick();
            tick();
            pop("simul_drain", 8'h00, got);
            check($sformatf("simul_drain_valid_%0d", k), 32'(got[0]), 32'h1);
            pop("simul_empty", 8'h00, got);
            check($sformatf("simul_empty_valid_%0d", k), 32'(got[0]), 32'h0);
        end

        // Overflow: depth+1 pushes, drain, then clear
        for (int i = 0; i <= int'(DEPTH); i++) fire(17'($urandom));
        pop("ovf_first", 8'h00, got);
        check("ovf_first_bit", 32'(got[1]), 32'h1);
        for (int i = 1; i < int'(DEPTH); i++) pop("ovf_drain", 8'h00, got);
        pop("ovf_empty", 8'h00, got);
        check("ovf_empty_valid", 32'(got[0]), 32'h0);
        check("ovf_empty_ovf", 32'(got[1]), 32'h1);
        clear_ovf();
        pop("ovf_cleared", 8'h00, got);
        check("ovf_cleared_bit", 32'(got[1]), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel < 5)       fire(17'($urandom));
            else if (sel < 8)  pop("rand_pop", 8'($urandom), got);
            else if (sel == 8) clear_ovf();
            else               repeat ($urandom_range(0, 7)) tick();
        end

        // Reset mid-operation discards records and restarts the drum
        fire(17'h1_FFFF);
        fire(17'h0_0F0F);
        pop("pre_reset_pop", 8'h00, got);
        #3 RES = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        #20;
        check("midreset_res", bus.PORT_RES, 32'h0);
        @(posedge CLK);
        #1 RES = 1'b0;
        check("post_reset_row", 32'(bus.PRN_ROW), 32'h0);
        check("post_reset_index", 32'(bus.PRN_INDEX), 32'h1);
        pop("post_reset_pop", 8'h00, got);
        check("post_reset_empty", got, 32'h8000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
